stage_e_mdu: RTL and testbench
==============================

Name: stage_e_mdu

Overview:
- Execute-stage multiply/divide unit.
- Consumes StartMDU, MoveToMDU, MoveFromMDU and MDUSel from the D/E pipeline register, plus the forwarded rs/rt operands.
- Owns the architectural HI/LO registers and models the multi-cycle latency of mult/div.
- Provides the busy indication the hazard unit uses to stall MDU-dependent instructions in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); clears all state immediately.
- start  input  1  StartMDU from D/E register; launch the operation selected by sel.
- move_to  input  1  MoveToMDU; write a into HI or LO per sel.
- move_from  input  1  MoveFromMDU; qualifies rdata (rdata is valid only when high).
- sel  input  3  MDUSel: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 HI, 101 LO; 110/111 reserved.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- busy  output  1  registered; high while an operation is in flight.
- rdata  output  32  combinational: HI when sel=100, LO when sel=101, else 0.
- hi  output  32  current HI (debug/trace).
- lo  output  32  current LO (debug/trace).

Behaviour:
- Reset (rst=0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result=0. rdata follows the combinational rule with the reset values.
- Idle state (busy=0), start=1 with sel in 000..011, sampled at edge T:
  - The full result is computed from a and b at T and latched into pending_hi/pending_lo.
  - counter loads N (MULT_CYCLES or DIV_CYCLES) and busy=1 after T.
  - The counter decrements each edge. At edge T+N, HI/LO take the pending values and busy drops.
  - Busy is therefore high for exactly N cycles.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI = upper 32 bits, LO = lower 32 bits.
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder with the dividend's sign.
  - DIVU: unsigned.
- Divide by zero (b=0, DIV/DIVU): the busy sequence runs normally, but HI/LO are left unchanged at completion.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- move_to=1 while idle, sel=100/101: HI/LO is written with a at that edge, with no busy period.
- start or move_to while busy=1: ignored. The hazard unit guarantees this does not happen; the bench checks the state is unaffected.
- start and move_to both high: start wins, move_to is ignored.
- sel=110/111 with start or move_to: no state change.
- start with sel=100/101: no state change.
- The hazard unit stalls any MDU instruction in D when (busy | start) is high. start is not folded into busy here.
- rdata reflects committed HI/LO only; pending values are never visible.
- Reset mid-operation: busy clears immediately, the pending result is discarded, HI/LO read 0.
- No flush input. The E register already zeroes start on flush, so no separate cancel path exists.

Decomposition:
- Shared package mdu_defs holds:
  - MDUSel encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_HI, MDU_LO.
  - Default latency constants.
  - These are reused by the decoder/control unit and the hazard unit.
- One sub-module, mdu_arith: combinational, taking sel, a, b and producing res_hi, res_lo, div_by_zero.
- Counter, busy and HI/LO registers stay in stage_e_mdu.

Test Plan:
- MULT a=0xFFFFFFFF, b=0x00000002 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. hi/lo unchanged while busy.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=7, b=2 -> LO=3, HI=1.
- Preload via move_to sel=100 a=0x1234, then sel=101 a=0x5678; DIVU b=0 -> busy 10 cycles, HI=0x1234 and LO=0x5678 retained.
- move_from sel=101 -> rdata=0x5678 the same cycle.
- MULT 3x4, then assert start (DIVU 9/3) and move_to (sel=100, a=0xDEAD) during cycle 2 of busy -> both ignored; final HI=0, LO=12.
- Separately, drive rst=0 during cycle 3 of a DIV -> busy=0 and HI=LO=0 without waiting for a clock edge; no late update once rst is released.

Source files
------------

// File: rtl/mdu_defs.sv
// Shared MDU definitions: MDUSel encodings and default multi-cycle latencies.
// Used by the E-stage MDU, the decoder/control unit and the hazard unit.
package mdu_defs;

    // MDUSel encodings; 3'b110 and 3'b111 are reserved.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_HI    = 3'b100,
        MDU_LO    = 3'b101
    } mdu_sel_e;

    // Default busy periods, in cycles.
    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: full 64-bit result of MULT/MULTU/DIV/DIVU.
// Ports:
//   sel         MDUSel (only 000..011 produce a result, others yield 0)
//   a, b        operands (rs, rt)
//   res_hi      HI part: product upper word, or remainder
//   res_lo      LO part: product lower word, or quotient
//   div_by_zero divide selected with b == 0
module mdu_arith
    import mdu_defs::*;
(
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_nz;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        div_ovf;
    logic        b_zero;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Substitute a harmless divisor so the dividers never see zero; the
    // result is discarded on divide by zero anyway.
    assign b_zero = (b == 32'd0);
    assign b_nz   = b_zero ? 32'd1 : b;

    // Most-negative / -1 overflows the signed quotient; pin the result.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign quo_s = $signed(a) / $signed(b_nz);
    assign rem_s = $signed(a) % $signed(b_nz);
    assign quo_u = a / b_nz;
    assign rem_u = a % b_nz;

    always_comb begin
        res_hi      = 32'd0;
        res_lo      = 32'd0;
        div_by_zero = 1'b0;
        case (sel)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV: begin
                div_by_zero = b_zero;
                if (div_ovf) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quo_s;
                end
            end
            MDU_DIVU: begin
                div_by_zero = b_zero;
                res_hi      = rem_u;
                res_lo      = quo_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/stage_e_mdu.sv
// Execute-stage multiply/divide unit. Owns HI/LO and models mult/div latency.
// Ports:
//   clk, rst     clock; asynchronous active-low reset
//   start        launch MULT/MULTU/DIV/DIVU selected by sel (ignored while busy)
//   move_to      write a into HI/LO selected by sel (ignored while busy or start)
//   move_from    qualifies rdata for the consumer
//   sel          MDUSel
//   a, b         forwarded rs/rt values
//   busy         registered; high for exactly N cycles after a launch
//   rdata        committed HI (sel=100), LO (sel=101), else 0
//   hi, lo       committed HI/LO for trace
module stage_e_mdu
    import mdu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        move_to,
    input  logic        move_from,
    input  logic [2:0]  sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_dz_q, pend_dz_d;
    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div_by_zero;
    logic        launch;
    logic        unused_move_from;

    // rdata is always driven; move_from only tells the consumer it is wanted.
    assign unused_move_from = move_from;

    mdu_arith u_arith (
        .sel         (sel),
        .a           (a),
        .b           (b),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    // sel[2] == 0 covers exactly MULT/MULTU/DIV/DIVU.
    assign launch = !busy_q && start && !sel[2];

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        if (busy_q) begin
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == CntW'(1)) begin
                busy_d = 1'b0;
                if (!pend_dz_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (launch) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_dz_d = div_by_zero;
            busy_d    = 1'b1;
            cnt_d     = sel[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        end else if (move_to && !start) begin
            if (sel == MDU_HI) begin
                hi_d = a;
            end else if (sel == MDU_LO) begin
                lo_d = a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel == MDU_HI) begin
            rdata = hi_q;
        end else if (sel == MDU_LO) begin
            rdata = lo_q;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_stage_e_mdu.sv
// Self-checking bench for stage_e_mdu: expected HI/LO pairs are queued when an
// operation is driven and popped when the DUT completes it.
module tb_stage_e_mdu;
    import mdu_defs::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        move_to;
    logic        move_from;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl_hi;
    logic [31:0] mdl_lo;
    int          n_checks;
    int          n_fails;

    stage_e_mdu dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .move_to   (move_to),
        .move_from (move_from),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .rdata     (rdata),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_state(input string tag);
        check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_hi"}, hi, mdl_hi);
        check_val({tag, "_lo"}, lo, mdl_lo);
    endtask

    // Launch an operation; optionally inject a start and a move_to mid-busy.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] opa,
                          input logic [31:0] opb, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_n, input bit inject);
        int   k;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        sel   = op;
        a     = opa;
        b     = opb;
        sb_q.push_back('{hi: exp_hi, lo: exp_lo});
        @(posedge clk);
        #1 start = 1'b0;
        k = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            k++;
            check_val({tag, "_hold_hi"}, hi, mdl_hi);
            check_val({tag, "_hold_lo"}, lo, mdl_lo);
            if (inject) begin
                if (k == 2) begin
                    start = 1'b1;
                    sel   = MDU_DIVU;
                    a     = 32'd9;
                    b     = 32'd3;
                end else if (k == 3) begin
                    start   = 1'b0;
                    move_to = 1'b1;
                    sel     = MDU_HI;
                    a       = 32'h0000_DEAD;
                end else begin
                    start   = 1'b0;
                    move_to = 1'b0;
                end
            end
        end
        start   = 1'b0;
        move_to = 1'b0;
        check_val({tag, "_busy_len"}, k, exp_n);
        e = sb_q.pop_front();
        check_val({tag, "_hi"}, hi, e.hi);
        check_val({tag, "_lo"}, lo, e.lo);
        mdl_hi = e.hi;
        mdl_lo = e.lo;
    endtask

    task automatic do_move(input string tag, input logic [2:0] s, input logic [31:0] v,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_t e;
        @(negedge clk);
        move_to = 1'b1;
        sel     = s;
        a       = v;
        sb_q.push_back('{hi: exp_hi, lo: exp_lo});
        @(posedge clk);
        #1 move_to = 1'b0;
        e = sb_q.pop_front();
        mdl_hi = e.hi;
        mdl_lo = e.lo;
        check_idle_state(tag);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        mdl_hi    = 32'd0;
        mdl_lo    = 32'd0;
        rst       = 1'b0;
        start     = 1'b0;
        move_to   = 1'b0;
        move_from = 1'b0;
        sel       = MDU_HI;
        a         = 32'd0;
        b         = 32'd0;

        #12;
        check_idle_state("reset");
        check_val("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("mult", MDU_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
        run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
        run_op("divu", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0);

        do_move("mthi", MDU_HI, 32'h0000_1234, 32'h0000_1234, 32'h8000_0000);
        do_move("mtlo", MDU_LO, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);
        run_op("divu_zero", MDU_DIVU, 32'd55, 32'd0, 32'h0000_1234, 32'h0000_5678, 10, 1'b0);

        // Combinational read path.
        @(negedge clk);
        move_from = 1'b1;
        sel       = MDU_LO;
        #1 check_val("mflo_rdata", rdata, 32'h0000_5678);
        sel = MDU_HI;
        #1 check_val("mfhi_rdata", rdata, 32'h0000_1234);
        sel = MDU_MULT;
        #1 check_val("rdata_other", rdata, 32'd0);
        move_from = 1'b0;

        // start with a move selector, and move_to with a reserved selector: no effect.
        @(negedge clk);
        start = 1'b1;
        sel   = MDU_HI;
        a     = 32'hAAAA_AAAA;
        @(posedge clk);
        #1 start = 1'b0;
        check_idle_state("start_sel_hi");
        @(negedge clk);
        move_to = 1'b1;
        sel     = 3'b110;
        a       = 32'hBBBB_BBBB;
        @(posedge clk);
        #1 move_to = 1'b0;
        check_idle_state("mt_reserved");

        // start and move_to together: start wins.
        @(negedge clk);
        start   = 1'b1;
        move_to = 1'b1;
        sel     = MDU_LO;
        a       = 32'hCCCC_CCCC;
        @(posedge clk);
        #1 start = 1'b0;
        move_to = 1'b0;
        check_idle_state("start_and_mt");

        run_op("busy_ignore", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1);

        // Asynchronous reset in the middle of a DIV.
        @(negedge clk);
        start = 1'b1;
        sel   = MDU_DIV;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        mdl_hi = 32'd0;
        mdl_lo = 32'd0;
        check_idle_state("async_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check_idle_state("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
